// File: rtl/fetch_vector_unit_pkg.sv
// Shared fetch definitions: vector slot codes, FSM state encoding and PC source select.
package fetch_vector_unit_pkg;

  // Slot codes match the fetch controller's fetchSrc encoding.
  localparam logic [1:0] VEC_RST = 2'b00;
  localparam logic [1:0] VEC_INT = 2'b01;

  typedef enum logic [1:0] {
    StNorm = 2'b00,
    StVhi  = 2'b01,
    StVlo  = 2'b10
  } fetch_state_e;

  typedef enum logic [1:0] {
    PcHold = 2'b00,
    PcInc  = 2'b01,
    PcLoad = 2'b10
  } pc_sel_e;

  // Word offset of a vector half inside the table: slot n uses 2n (hi) and 2n+1 (lo).
  function automatic logic [2:0] vec_word_offset(input logic [1:0] src, input logic lo);
    return {src, lo};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: holds, increments (wrapping) or loads a {hi,lo} vector.
module fetch_pc_reg
  import fetch_vector_unit_pkg::*;
#(
  parameter int unsigned           PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_val,
  output logic [PC_WIDTH-1:0] pc
);

  pc_sel_e             sel;
  logic [PC_WIDTH-1:0] pc_q, pc_d;

  // A vector load always wins over a concurrent increment.
  always_comb begin
    sel = PcHold;
    if (load) begin
      sel = PcLoad;
    end else if (inc) begin
      sel = PcInc;
    end
  end

  always_comb begin
    pc_d = pc_q;
    unique case (sel)
      PcInc:   pc_d = pc_q + PC_WIDTH'(1);
      PcLoad:  pc_d = load_val;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_vector_unit.sv
// Instruction-fetch datapath: streams words from the PC and loads two-word vectors on request.
module fetch_vector_unit
  import fetch_vector_unit_pkg::*;
#(
  parameter int unsigned                DATA_WIDTH = 16,
  parameter logic [2*DATA_WIDTH-1:0]    VEC_BASE   = '0,
  parameter logic [2*DATA_WIDTH-1:0]    RESET_PC   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch,
  input  logic                    extend,
  input  logic [1:0]              fetchSrc,
  input  logic                    stall,
  output logic                    memRead,
  output logic [2*DATA_WIDTH-1:0] memAddr,
  input  logic [DATA_WIDTH-1:0]   memData,
  input  logic                    memReady,
  output logic [DATA_WIDTH-1:0]   instr,
  output logic                    valid,
  output logic [2*DATA_WIDTH-1:0] pc,
  output logic                    vecBusy
);

  localparam int unsigned PcWidth = 2 * DATA_WIDTH;

  fetch_state_e          state_q;
  logic [1:0]            src_q;
  logic [DATA_WIDTH-1:0] hi_q;

  logic                  read_req;
  logic                  read_done;
  logic                  pc_inc;
  logic                  pc_load;
  logic [PcWidth-1:0]    vec_addr;

  assign vec_addr = VEC_BASE + PcWidth'(vec_word_offset(src_q, state_q == StVlo));

  always_comb begin
    read_req = 1'b0;
    memAddr  = pc;
    unique case (state_q)
      StNorm: begin
        read_req = !stall;
        memAddr  = pc;
      end
      StVhi, StVlo: begin
        read_req = 1'b1;
        memAddr  = vec_addr;
      end
      default: begin
        read_req = 1'b0;
        memAddr  = pc;
      end
    endcase
  end

  // Gate the strobe with reset so nothing is requested while the unit is held in reset.
  assign memRead   = read_req & rst;
  assign read_done = memRead & memReady;
  assign valid     = read_done & (state_q == StNorm);
  assign instr     = valid ? memData : '0;
  assign pc_inc    = valid;
  assign pc_load   = read_done & (state_q == StVlo);
  assign vecBusy   = (state_q != StNorm);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StNorm;
      src_q   <= VEC_RST;
      hi_q    <= '0;
    end else begin
      unique case (state_q)
        StNorm: begin
          if (fetch && extend) begin
            src_q   <= fetchSrc;
            state_q <= StVhi;
          end
        end
        StVhi: begin
          if (memReady) begin
            hi_q    <= memData;
            state_q <= StVlo;
          end
        end
        StVlo: begin
          if (memReady) begin
            state_q <= StNorm;
          end
        end
        default: state_q <= StNorm;
      endcase
    end
  end

  fetch_pc_reg #(
    .PC_WIDTH (PcWidth),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val ({hi_q, memData}),
    .pc       (pc)
  );

endmodule

// File: tb/tb_fetch_vector_unit.sv
// Directed bench for fetch_vector_unit: streaming, vector loads, stalls, wrap and async reset.
module tb_fetch_vector_unit;

  logic        clk;
  logic        rst;
  logic        fetch;
  logic        extend;
  logic [1:0]  fetchSrc;
  logic        stall;
  logic        memRead;
  logic [31:0] memAddr;
  logic [15:0] memData;
  logic        memReady;
  logic [15:0] instr;
  logic        valid;
  logic [31:0] pc;
  logic        vecBusy;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_vector_unit #(
    .DATA_WIDTH (16),
    .VEC_BASE   (32'h0),
    .RESET_PC   (32'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch    (fetch),
    .extend   (extend),
    .fetchSrc (fetchSrc),
    .stall    (stall),
    .memRead  (memRead),
    .memAddr  (memAddr),
    .memData  (memData),
    .memReady (memReady),
    .instr    (instr),
    .valid    (valid),
    .pc       (pc),
    .vecBusy  (vecBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector table in words 0..7; everything else reads as a plain instruction word.
  function automatic logic [15:0] mem_model(input logic [31:0] a);
    case (a)
      32'd0:   return 16'h0000;
      32'd1:   return 16'h0100;
      32'd2:   return 16'h0000;
      32'd3:   return 16'h2000;
      32'd4:   return 16'hFFFF;
      32'd5:   return 16'hFFFF;
      32'd6:   return 16'hABCD;
      32'd7:   return 16'h0000;
      default: return 16'h1111;
    endcase
  endfunction

  assign memData = mem_model(memAddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // The controller must never fetch while a vector load is in flight.
  always @(posedge clk) begin
    if (rst === 1'b1 && fetch === 1'b1 && vecBusy === 1'b1) begin
      n_tests++;
      n_fail++;
      $error("FAIL fetch_while_busy: observed 1 expected 0");
    end
  end

  initial begin
    rst      = 1'b0;
    fetch    = 1'b0;
    extend   = 1'b0;
    fetchSrc = 2'b00;
    stall    = 1'b0;
    memReady = 1'b1;

    // Held in reset
    @(negedge clk); #1;
    chk("rst_memRead", memRead, 0);
    chk("rst_valid", valid, 0);
    chk("rst_vecBusy", vecBusy, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, 0);

    // Streaming
    @(negedge clk); rst = 1'b1; #1;
    chk("s0_memRead", memRead, 1);
    chk("s0_addr", memAddr, 32'd0);
    chk("s0_valid", valid, 1);
    chk("s0_instr", instr, 16'h0000);
    chk("s0_pc", pc, 32'd0);
    @(negedge clk); #1;
    chk("s1_addr", memAddr, 32'd1);
    chk("s1_instr", instr, 16'h0100);
    chk("s1_pc", pc, 32'd1);
    @(negedge clk); #1;
    chk("s2_addr", memAddr, 32'd2);
    chk("s2_pc", pc, 32'd2);
    chk("s2_valid", valid, 1);

    // Reset-vector load requested on a valid cycle
    fetch = 1'b1; extend = 1'b1; fetchSrc = 2'b00;
    @(negedge clk); fetch = 1'b0; extend = 1'b0; #1;
    chk("rv_hi_busy", vecBusy, 1);
    chk("rv_hi_addr", memAddr, 32'd0);
    chk("rv_hi_valid", valid, 0);
    chk("rv_hi_memRead", memRead, 1);
    chk("rv_hi_pc", pc, 32'd3);
    @(negedge clk); #1;
    chk("rv_lo_busy", vecBusy, 1);
    chk("rv_lo_addr", memAddr, 32'd1);
    chk("rv_lo_valid", valid, 0);
    @(negedge clk); #1;
    chk("rv_done_busy", vecBusy, 0);
    chk("rv_done_pc", pc, 32'h0000_0100);
    chk("rv_done_addr", memAddr, 32'h0000_0100);
    chk("rv_done_instr", instr, 16'h1111);

    // Interrupt vector with memory ready every third cycle
    fetch = 1'b1; extend = 1'b1; fetchSrc = 2'b01;
    @(negedge clk); fetch = 1'b0; extend = 1'b0; memReady = 1'b0; #1;
    chk("iv_hi0_busy", vecBusy, 1);
    chk("iv_hi0_addr", memAddr, 32'd2);
    chk("iv_hi0_valid", valid, 0);
    @(negedge clk); #1;
    chk("iv_hi1_addr", memAddr, 32'd2);
    @(negedge clk); memReady = 1'b1; #1;
    chk("iv_hi2_addr", memAddr, 32'd2);
    chk("iv_hi2_busy", vecBusy, 1);
    @(negedge clk); memReady = 1'b0; #1;
    chk("iv_lo0_addr", memAddr, 32'd3);
    chk("iv_lo0_busy", vecBusy, 1);
    chk("iv_lo0_pc", pc, 32'h0000_0101);
    @(negedge clk); #1;
    chk("iv_lo1_addr", memAddr, 32'd3);
    @(negedge clk); memReady = 1'b1; #1;
    chk("iv_lo2_addr", memAddr, 32'd3);
    chk("iv_lo2_valid", valid, 0);
    chk("iv_lo2_busy", vecBusy, 1);
    @(negedge clk); #1;
    chk("iv_done_busy", vecBusy, 0);
    chk("iv_done_pc", pc, 32'h0000_2000);
    chk("iv_done_addr", memAddr, 32'h0000_2000);
    chk("iv_done_valid", valid, 1);

    // Stall in NORM holds the PC
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); stall = 1'b1; #1;
      chk($sformatf("stall%0d_memRead", i), memRead, 0);
      chk($sformatf("stall%0d_valid", i), valid, 0);
      chk($sformatf("stall%0d_pc", i), pc, 32'h0000_2001);
    end

    // Vector request wins over stall; stall ignored during the load
    @(negedge clk); fetch = 1'b1; extend = 1'b1; fetchSrc = 2'b10;
    @(negedge clk); fetch = 1'b0; extend = 1'b0; #1;
    chk("sv_hi_memRead", memRead, 1);
    chk("sv_hi_addr", memAddr, 32'd4);
    chk("sv_hi_busy", vecBusy, 1);
    @(negedge clk); #1;
    chk("sv_lo_addr", memAddr, 32'd5);
    @(negedge clk); stall = 1'b0; #1;
    chk("sv_done_pc", pc, 32'hFFFF_FFFF);
    chk("sv_done_addr", memAddr, 32'hFFFF_FFFF);
    chk("sv_done_valid", valid, 1);

    // PC wraps; fetch without extend is ignored
    @(negedge clk); #1;
    chk("wrap_pc", pc, 32'd0);
    chk("wrap_addr", memAddr, 32'd0);
    chk("wrap_instr", instr, 16'h0000);
    fetch = 1'b1; extend = 1'b0; fetchSrc = 2'b01;
    @(negedge clk); fetch = 1'b0; #1;
    chk("noext_busy", vecBusy, 0);
    chk("noext_pc", pc, 32'd1);
    chk("noext_addr", memAddr, 32'd1);

    // Async reset in the middle of VLO
    fetch = 1'b1; extend = 1'b1; fetchSrc = 2'b11;
    @(negedge clk); fetch = 1'b0; extend = 1'b0; #1;
    chk("ar_hi_addr", memAddr, 32'd6);
    @(negedge clk); memReady = 1'b0; #1;
    chk("ar_lo_addr", memAddr, 32'd7);
    chk("ar_lo_busy", vecBusy, 1);
    #1; rst = 1'b0; #1;
    chk("ar_pc", pc, 32'd0);
    chk("ar_busy", vecBusy, 0);
    chk("ar_memRead", memRead, 0);
    chk("ar_valid", valid, 0);
    @(negedge clk); rst = 1'b1; memReady = 1'b1; #1;
    chk("ar_restart_addr", memAddr, 32'd0);
    chk("ar_restart_pc", pc, 32'd0);
    chk("ar_restart_valid", valid, 1);
    chk("ar_restart_instr", instr, 16'h0000);
    @(negedge clk); #1;
    chk("ar_next_pc", pc, 32'd1);
    chk("ar_next_busy", vecBusy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
